mpu_fetch: RTL
==============

MPU_FETCH -- requirements
Module: mpu_fetch

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, ports clk and rst_n.
REQ-002 clk  input  1  rising-edge system clock.
REQ-003 rst_n  input  1  asynchronous active-low reset; deassertion is synchronous to clk at the instantiating level.
REQ-004 halt  input  1  level; high blocks issue of new memory requests.
REQ-005 jump_en  input  1  one-cycle pulse; load PC from jump_addr.
REQ-006 jump_addr  input  12  jump target.
REQ-007 mem_req  output  1  memory read request.
REQ-008 mem_addr  output  12  read address, valid while mem_req is high.
REQ-009 mem_ack  input  1  memory read complete; mem_rdata is valid in the same cycle.
REQ-010 mem_rdata  input  8  read byte.
REQ-011 instr_valid  output  1  instruction bundle available to the core.
REQ-012 instr_ready  input  1  core accepts the bundle.
REQ-013 instr_op  output  8  opcode byte.
REQ-014 instr_arg1, instr_arg2, instr_arg3  output  8 each  operand bytes, in fetch order.
REQ-015 instr_pc  output  12  address of the opcode byte in the current bundle.

Function
REQ-016 The operand count SHALL be opcode bits [7:6] (0..3); the fetched bundle SHALL be opcode plus that many operand bytes.
REQ-017 The FSM SHALL have states IDLE, FETCH_OP, FETCH_ARG, HOLD.
- IDLE -> FETCH_OP on the first edge after reset release.
- FETCH_OP -> FETCH_ARG on ack if count > 0, otherwise -> HOLD.
- FETCH_ARG -> FETCH_ARG on ack until the last argument, then -> HOLD.
- HOLD -> FETCH_OP on instr_valid & instr_ready.
REQ-018 In FETCH states, mem_req SHALL be held high with mem_addr = PC stable until mem_ack is sampled high.
REQ-019 On each ack edge, the block SHALL capture mem_rdata into the current slot, set PC <= PC+1 modulo 4096 (0xFFF wraps to 0x000), and drive mem_req low for at least one cycle.
REQ-020 Each byte SHALL take at least 2 cycles: 1 cycle of request, then ack, then 1 idle cycle.
REQ-021 instr_valid SHALL rise on the edge that captures the last byte of the bundle.
REQ-022 All bundle outputs SHALL stay stable while instr_valid is high and instr_ready is low.
REQ-023 Argument slots beyond the operand count SHALL read 0x00.
REQ-024 On the edge where instr_valid and instr_ready are both high, instr_valid SHALL fall; mem_req for the next opcode SHALL rise on that same edge unless halt is high.
REQ-025 halt high SHALL NOT abort a request already raised; it completes on ack.
REQ-026 While halt is high, no new mem_req SHALL rise, the PC SHALL be held, and any HOLD bundle SHALL be retained.
REQ-027 Fetching SHALL resume on the first edge with halt low.
REQ-028 jump_en SHALL have priority over all other events:
- PC <= jump_addr.
- Any partial or held bundle is discarded; instr_valid goes to 0.
- State -> FETCH_OP.
- If mem_req is high without ack, it drops, and the new request rises after one idle cycle.
- If jump_en and mem_ack coincide, the data is discarded.
REQ-029 If jump_en and instr_ready coincide while valid, the bundle SHALL count as consumed; the jump still applies.
REQ-030 If jump_en and halt are both high, the block SHALL load the PC and then wait for halt to release.

Reset
REQ-031 Asserting rst_n low SHALL immediately set, with no clock required:
- state = IDLE, PC = 0x000, mem_req = 0, mem_addr = 0x000;
- instr_valid = 0, instr_op, instr_arg1..3 = 0x00, instr_pc = 0x000.
REQ-032 Reset mid-transaction SHALL abandon the request; a late mem_ack during or after reset SHALL be ignored.

Structure
REQ-033 The shared package mpu_pkg SHALL hold: PC_WIDTH = 12, the FSM state enumeration, and the opcode-to-operand-count rule (bits [7:6]).
REQ-034 The block SHALL be a single module with no sub-modules; the PC register and the FSM live in mpu_fetch.

Verification
REQ-035 The bench SHALL cover these directed scenarios:
- Zero-wait memory, opcode 0x05 at address 0, instr_ready tied high -> bundle op=0x05, args=0, pc=0x000; instr_valid rises 2 cycles after the first mem_req; next request addr=0x001.
- Opcode 0xC1 followed by bytes 0x11, 0x22, 0x33 -> args 0x11/0x22/0x33, PC=0x004 after the bundle.
- instr_ready held low for 5 cycles -> outputs stable, no mem_req; on the ready edge, mem_req rises with addr=next PC.
- PC=0xFFF, opcode 0x40 -> operand is read from 0x000, next opcode from 0x001.
- halt raised during an outstanding argument request -> the request completes, no further mem_req while halted, fetch resumes one edge after release.
- jump_en with jump_addr=0x123 coinciding with mem_ack in FETCH_ARG -> data discarded, instr_valid stays 0, next mem_addr = 0x123 after one idle cycle.

Source files
------------

// File: rtl/mpu_pkg.sv
// Shared definitions for the MPU instruction fetch path: PC width,
// fetch FSM states and the opcode operand-count rule.
package mpu_pkg;

   localparam int unsigned PC_WIDTH = 12;

   typedef enum logic [1:0] {
      IDLE,
      FETCH_OP,
      FETCH_ARG,
      HOLD
   } fetch_state_e;

   // The two top opcode bits give the number of operand bytes that follow.
   function automatic logic [1:0] op_arg_count(input logic [7:0] op);
      return op[7:6];
   endfunction

endpackage

// File: rtl/mpu_fetch_if.sv
// Fetch unit bus: byte-wide memory read port plus instruction bundle handshake.
interface mpu_fetch_if;
   import mpu_pkg::*;

   logic                mem_req;
   logic [PC_WIDTH-1:0] mem_addr;
   logic                mem_ack;
   logic [7:0]          mem_rdata;

   logic                instr_valid;
   logic                instr_ready;
   logic [7:0]          instr_op;
   logic [7:0]          instr_arg1;
   logic [7:0]          instr_arg2;
   logic [7:0]          instr_arg3;
   logic [PC_WIDTH-1:0] instr_pc;

   modport master (
      output mem_req, mem_addr,
      input  mem_ack, mem_rdata,
      output instr_valid, instr_op, instr_arg1, instr_arg2, instr_arg3, instr_pc,
      input  instr_ready
   );

   modport slave (
      input  mem_req, mem_addr,
      output mem_ack, mem_rdata,
      input  instr_valid, instr_op, instr_arg1, instr_arg2, instr_arg3, instr_pc,
      output instr_ready
   );

endinterface

// File: rtl/mpu_fetch.sv
// Instruction fetch: reads an opcode plus 0..3 operand bytes one byte per
// memory request and presents them as a bundle until the core accepts it.
module mpu_fetch
   import mpu_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                halt,
   input  logic                jump_en,
   input  logic [PC_WIDTH-1:0] jump_addr,
   mpu_fetch_if.master         bus
);

   fetch_state_e        state;
   logic [PC_WIDTH-1:0] pc;
   logic [1:0]          arg_cnt;
   logic [1:0]          arg_idx;
   logic                byte_done;
   logic                consume;

   // Acks are only honoured against our own live request, so a stale ack
   // after reset or after a jump-dropped request is ignored.
   assign byte_done = bus.mem_req & bus.mem_ack;
   assign consume   = bus.instr_valid & bus.instr_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= IDLE;
         pc              <= '0;
         arg_cnt         <= '0;
         arg_idx         <= '0;
         bus.mem_req     <= 1'b0;
         bus.mem_addr    <= '0;
         bus.instr_valid <= 1'b0;
         bus.instr_op    <= '0;
         bus.instr_arg1  <= '0;
         bus.instr_arg2  <= '0;
         bus.instr_arg3  <= '0;
         bus.instr_pc    <= '0;
      end else if (jump_en) begin
         pc              <= jump_addr;
         state           <= FETCH_OP;
         arg_cnt         <= '0;
         arg_idx         <= '0;
         bus.mem_req     <= 1'b0;
         bus.instr_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: state <= FETCH_OP;

            FETCH_OP, FETCH_ARG: begin
               if (byte_done) begin
                  bus.mem_req <= 1'b0;
                  pc          <= pc + PC_WIDTH'(1);
                  if (state == FETCH_OP) begin
                     bus.instr_op   <= bus.mem_rdata;
                     bus.instr_pc   <= pc;
                     bus.instr_arg1 <= '0;
                     bus.instr_arg2 <= '0;
                     bus.instr_arg3 <= '0;
                     arg_cnt        <= op_arg_count(bus.mem_rdata);
                     arg_idx        <= 2'd1;
                     if (op_arg_count(bus.mem_rdata) == 2'd0) begin
                        bus.instr_valid <= 1'b1;
                        state           <= HOLD;
                     end else begin
                        state <= FETCH_ARG;
                     end
                  end else begin
                     case (arg_idx)
                        2'd1:    bus.instr_arg1 <= bus.mem_rdata;
                        2'd2:    bus.instr_arg2 <= bus.mem_rdata;
                        2'd3:    bus.instr_arg3 <= bus.mem_rdata;
                        default: ;
                     endcase
                     if (arg_idx == arg_cnt) begin
                        bus.instr_valid <= 1'b1;
                        state           <= HOLD;
                     end else begin
                        arg_idx <= arg_idx + 2'd1;
                     end
                  end
               end else if (!bus.mem_req && !halt) begin
                  bus.mem_req  <= 1'b1;
                  bus.mem_addr <= pc;
               end
            end

            HOLD: begin
               // Next opcode request is issued on the accept edge itself.
               if (consume) begin
                  bus.instr_valid <= 1'b0;
                  state           <= FETCH_OP;
                  if (!halt) begin
                     bus.mem_req  <= 1'b1;
                     bus.mem_addr <= pc;
                  end
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule
